vga_sync_monitor: RTL and testbench

- Receive-side checker for the VGA interface the display path drives (hSync, vSync, 12-bit RGB, Nexys4 100 MHz system clock, 640x480 at 25 MHz pixel rate).
- Recovers line and frame position from the sync pulses alone, checks every line and frame against the expected timing, and declares lock.
- Samples the pixel colour at a programmable probe coordinate.
- Used on-board, driving LEDs and the SSD, and in simulation as a scoreboard for the display path.

---
 rtl/vga_sync_monitor.sv | 188 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers line/frame position from the syncs, flags timing errors, locks, probes one pixel.
// Inputs are registered once; errors, lock state and probe capture appear one cycle after the registered edge; no backpressure.
module vga_sync_monitor #(
  parameter int CPP         = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  input  logic [9:0]  ProbeX,
  input  logic [9:0]  ProbeY,
  input  logic        ClearErr,
  output logic        Locked,
  output logic        HErr,
  output logic        VErr,
  output logic [15:0] FrameCount,
  output logic [11:0] ProbeRgb,
  output logic        ProbeValid
);

  localparam int PW = $clog2(CPP);
  localparam logic [11:0]   SYNC_CLKS  = 12'(H_SYNC * CPP);
  localparam logic [11:0]   LINE_LAST  = 12'(H_TOTAL * CPP - 1);
  localparam logic [9:0]    V_SYNC_L   = 10'(V_SYNC);
  localparam logic [9:0]    FRAME_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0]   H_TOTAL_L  = 11'(H_TOTAL);
  localparam logic [10:0]   V_TOTAL_L  = 11'(V_TOTAL);
  localparam logic [PW-1:0] PHASE_MID  = PW'(CPP / 2);
  localparam logic [3:0]    LOCK_L     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} stateT;

  logic        hSyncR, vSyncR, hSyncP, vSyncP;
  logic [11:0] rgbR;
  logic        hFall, hRise, vFall, vRise;
  logic [11:0] clkCnt, lastCnt, pixCol;
  logic [9:0]  lineCnt, lineNext;
  logic        hSeen, vSeen;
  logic        hErrNow, vErrNow;
  logic        frameErr, frameBad;
  logic [3:0]  good, goodInc;
  stateT       state;
  logic        probeHit;

  // Previous-value registers reset high so nothing looks like an edge right after Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hSyncR <= 1'b1;
      vSyncR <= 1'b1;
      hSyncP <= 1'b1;
      vSyncP <= 1'b1;
      rgbR   <= '0;
    end else begin
      hSyncR <= hSync;
      vSyncR <= vSync;
      hSyncP <= hSyncR;
      vSyncP <= vSyncR;
      rgbR   <= rgb;
    end
  end

  assign hFall = hSyncP & ~hSyncR;
  assign hRise = ~hSyncP & hSyncR;
  assign vFall = vSyncP & ~vSyncR;
  assign vRise = ~vSyncP & vSyncR;

  // Restart is keyed off the raw input so clkCnt already reads 0 when the registered fall is seen;
  // lastCnt keeps the final count of the line that just ended.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clkCnt  <= '0;
      lastCnt <= '0;
    end else begin
      lastCnt <= clkCnt;
      if (hSyncR && !hSync)
        clkCnt <= '0;
      else if (clkCnt != 12'hFFF)
        clkCnt <= clkCnt + 12'd1;
    end
  end

  always_comb begin
    lineNext = lineCnt;
    if (vFall)
      lineNext = '0;
    else if (hFall && lineCnt != 10'h3FF)
      lineNext = lineCnt + 10'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lineCnt <= '0;
      hSeen   <= 1'b0;
      vSeen   <= 1'b0;
    end else begin
      lineCnt <= lineNext;
      hSeen   <= hSeen | hFall;
      vSeen   <= vSeen | vFall;
    end
  end

  // The vSync rise normally shares its cycle with an hSync fall, so the width check sees the updated line count.
  assign hErrNow = hSeen & ((hRise & (clkCnt != SYNC_CLKS)) | (hFall & (lastCnt != LINE_LAST)));
  assign vErrNow = vSeen & ((vRise & (lineNext != V_SYNC_L)) | (vFall & (lineCnt != FRAME_LAST)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      HErr <= 1'b0;
      VErr <= 1'b0;
    end else begin
      HErr <= (HErr & ~ClearErr) | hErrNow;
      VErr <= (VErr & ~ClearErr) | vErrNow;
    end
  end

  assign frameBad = frameErr | hErrNow | vErrNow;
  assign goodInc  = good + 4'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= SEARCH;
      good       <= '0;
      frameErr   <= 1'b0;
      Locked     <= 1'b0;
      FrameCount <= '0;
    end else begin
      frameErr <= vFall ? 1'b0 : frameBad;
      case (state)
        SEARCH: begin
          if (vFall) begin
            state <= ALIGN;
            good  <= '0;
          end
        end
        ALIGN: begin
          if (vFall) begin
            if (frameBad) begin
              good <= '0;
            end else if (goodInc == LOCK_L) begin
              good       <= goodInc;
              state      <= LOCKED;
              Locked     <= 1'b1;
              FrameCount <= FrameCount + 16'd1;
            end else begin
              good <= goodInc;
            end
          end
        end
        LOCKED: begin
          if (vFall)
            FrameCount <= FrameCount + 16'd1;
          if (hErrNow || vErrNow) begin
            state  <= SEARCH;
            Locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          Locked <= 1'b0;
        end
      endcase
    end
  end

  // Sample mid-pixel so the capture is clear of pixel transitions.
  assign pixCol   = clkCnt >> PW;
  assign probeHit = (pixCol == {2'b00, ProbeX}) && (lineCnt == ProbeY) &&
                    (clkCnt[PW-1:0] == PHASE_MID) &&
                    ({1'b0, ProbeX} < H_TOTAL_L) && ({1'b0, ProbeY} < V_TOTAL_L);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ProbeRgb   <= '0;
      ProbeValid <= 1'b0;
    end else begin
      ProbeValid <= probeHit;
      if (probeHit)
        ProbeRgb <= rgbR;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboarded bench for vga_sync_monitor on a reduced 20x8 raster (CPP=4, 80 clocks/line, 640 clocks/frame).
module tb_vga_sync_monitor;

  localparam int CPP = 4, H_TOTAL = 20, H_SYNC = 3, V_TOTAL = 8, V_SYNC = 2, LOCK_FRAMES = 2;
  localparam int LC = H_TOTAL * CPP;
  localparam int K_LOCK = 0, K_HERR = 1, K_VERR = 2, K_FC = 3, K_PROBE = 4;

  logic        Clk = 1'b0;
  logic        Reset, hSync, vSync, ClearErr;
  logic [11:0] rgb;
  logic [9:0]  ProbeX, ProbeY;
  logic        Locked, HErr, VErr, ProbeValid;
  logic [15:0] FrameCount;
  logic [11:0] ProbeRgb;

  vga_sync_monitor #(
    .CPP(CPP), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .hSync(hSync), .vSync(vSync), .rgb(rgb),
    .ProbeX(ProbeX), .ProbeY(ProbeY), .ClearErr(ClearErr),
    .Locked(Locked), .HErr(HErr), .VErr(VErr), .FrameCount(FrameCount),
    .ProbeRgb(ProbeRgb), .ProbeValid(ProbeValid)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; int val; } evT;
  evT evQ[$];
  int nChecks = 0, nFail = 0;
  bit monOn = 1'b0;

  // Frame plan: defaults describe a nominal frame.
  int planLines = V_TOTAL, modLine = -1, modLen = H_TOTAL, modSync = H_SYNC;
  int clrLine = -1, clrOff = 0, rstLine = -1, rstOff = 0;
  int probePx = 25, probePy = 3;
  bit probeOn = 1'b0;
  int fs;

  task automatic push(input int k, input int c, input int v);
    evQ.push_back('{kind: k, cyc: c, val: v});
  endtask

  task automatic check(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_locked"}, int'(Locked), 0);
    check({tag, "_herr"}, int'(HErr), 0);
    check({tag, "_verr"}, int'(VErr), 0);
    check({tag, "_framecount"}, int'(FrameCount), 0);
    check({tag, "_probergb"}, int'(ProbeRgb), 0);
    check({tag, "_probevalid"}, int'(ProbeValid), 0);
  endtask

  task automatic popCheck(input int kind, input string nm, input int act);
    int idx;
    idx = -1;
    for (int i = 0; i < evQ.size(); i++)
      if (idx < 0 && evQ[i].kind == kind) idx = i;
    nChecks++;
    if (idx < 0) begin
      nFail++;
      $display("FAIL %s: unexpected change to %0h at cycle %0d", nm, act, cyc);
    end else begin
      if (evQ[idx].cyc != cyc || evQ[idx].val != act) begin
        nFail++;
        $display("FAIL %s: got value %0h at cycle %0d, expected value %0h at cycle %0d",
                 nm, act, cyc, evQ[idx].val, evQ[idx].cyc);
      end
      evQ.delete(idx);
    end
  endtask

  // Monitor: every observable output change must match the next expected event of its kind.
  logic        pLocked, pHErr, pVErr;
  logic [15:0] pFc;
  always @(negedge Clk) begin
    if (monOn) begin
      if (ProbeValid)         popCheck(K_PROBE, "probe", int'(ProbeRgb));
      if (Locked != pLocked)  popCheck(K_LOCK, "locked", int'(Locked));
      if (HErr != pHErr)      popCheck(K_HERR, "herr", int'(HErr));
      if (VErr != pVErr)      popCheck(K_VERR, "verr", int'(VErr));
      if (FrameCount != pFc)  popCheck(K_FC, "framecount", int'(FrameCount));
    end
    pLocked = Locked;
    pHErr   = HErr;
    pVErr   = VErr;
    pFc     = FrameCount;
  end

  task automatic runLine(input int len, input int sync, input bit vLow, input bit probeLine,
                         input int clrC, input int rstC);
    for (int c = 0; c < len * CPP; c++) begin
      hSync    = (c < sync * CPP) ? 1'b0 : 1'b1;
      vSync    = ~vLow;
      rgb      = (probeLine && (c / CPP) == probePx) ? 12'hF00 : 12'h000;
      ClearErr = (c == clrC);
      Reset    = (c == rstC);
      if (rstC >= 0 && c == rstC + 1) checkZero("midline_reset");
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic runFrame();
    for (int l = 0; l < planLines; l++)
      runLine((l == modLine) ? modLen : H_TOTAL, (l == modLine) ? modSync : H_SYNC,
              l < V_SYNC, probeOn && (l == probePy),
              (l == clrLine) ? clrOff : -1, (l == rstLine) ? rstOff : -1);
    planLines = V_TOTAL; modLine = -1; modLen = H_TOTAL; modSync = H_SYNC;
    clrLine = -1; clrOff = 0; rstLine = -1; rstOff = 0;
  endtask

  initial begin
    Reset = 1'b1; hSync = 1'b1; vSync = 1'b1; rgb = '0; ClearErr = 1'b0;
    ProbeX = 10'(probePx); ProbeY = 10'(probePy);
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkZero("reset");
    monOn = 1'b1;

    // Frames 0..2: enter ALIGN, two clean frames, lock at the third vSync fall.
    runFrame();
    runFrame();
    fs = cyc; push(K_LOCK, fs + 2, 1); push(K_FC, fs + 2, 1);
    runFrame();

    // Frame 3: locked; line 4 is one pixel short.
    fs = cyc; push(K_FC, fs + 2, 2);
    modLine = 4; modLen = H_TOTAL - 1;
    push(K_HERR, fs + 4 * LC + (H_TOTAL - 1) * CPP + 2, 1);
    push(K_LOCK, fs + 4 * LC + (H_TOTAL - 1) * CPP + 2, 0);
    runFrame();
    runFrame();
    runFrame();

    // Frame 6: relocked; line 3 hSync one pixel narrow with ClearErr in the detection cycle.
    fs = cyc; push(K_LOCK, fs + 2, 1); push(K_FC, fs + 2, 3);
    modLine = 3; modSync = H_SYNC - 1;
    clrLine = 3; clrOff = (H_SYNC - 1) * CPP + 1;
    push(K_LOCK, fs + 3 * LC + (H_SYNC - 1) * CPP + 2, 0);
    runFrame();
    check("herr_kept_on_coincident_clear", int'(HErr), 1);

    // Frame 7: lone ClearErr drops HErr.
    fs = cyc; clrLine = 1; clrOff = 10;
    push(K_HERR, fs + LC + 10 + 1, 0);
    runFrame();
    runFrame();

    // Frame 9: locked, one line short of a full frame.
    fs = cyc; push(K_LOCK, fs + 2, 1); push(K_FC, fs + 2, 4);
    planLines = V_TOTAL - 1;
    runFrame();

    // Frames 10-11: VErr at the vSync fall; probe pixel (5,3) lit in both frames.
    fs = cyc; push(K_VERR, fs + 2, 1); push(K_LOCK, fs + 2, 0); push(K_FC, fs + 2, 5);
    probePx = 5; probePy = 3; probeOn = 1'b1; ProbeX = 10'd5; ProbeY = 10'd3;
    push(K_PROBE, fs + 3 * LC + 5 * CPP + 4, 12'hF00);
    runFrame();
    fs = cyc; push(K_PROBE, fs + 3 * LC + 5 * CPP + 4, 12'hF00);
    runFrame();

    // Frame 12: probe column beyond the line never captures.
    probePx = 25; probeOn = 1'b0; ProbeX = 10'd25;
    runFrame();

    // Frame 13: lock, then Reset mid-line 2.
    fs = cyc; push(K_LOCK, fs + 2, 1); push(K_FC, fs + 2, 6);
    rstLine = 2; rstOff = 30;
    push(K_LOCK, fs + 2 * LC + 31, 0); push(K_FC, fs + 2 * LC + 31, 0);
    push(K_VERR, fs + 2 * LC + 31, 0);
    runFrame();

    // Frames 14-16: unchecked first fall after Reset, then relock from FrameCount 0.
    runFrame();
    runFrame();
    fs = cyc; push(K_LOCK, fs + 2, 1); push(K_FC, fs + 2, 1);
    runFrame();

    repeat (10) @(posedge Clk);
    #1;
    nChecks++;
    if (evQ.size() != 0) begin
      nFail++;
      $display("FAIL pending_events: %0d expected events never seen, first kind %0d at cycle %0d",
               evQ.size(), evQ[0].kind, evQ[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
